// File: rtl/lcd_status_reader.sv
// Timed HD44780 read cycles (RW=1): returns busy flag / address counter or a data byte,
// with optional status polling until BF=0 or a poll limit is reached.
module lcd_status_reader #(
    parameter int T_AS      = 8,
    parameter int T_PW      = 25,
    parameter int T_REC     = 25,
    parameter int MAX_POLLS = 255,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       mode,
    input  logic       poll,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       bus_owned,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout
);

    typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_AS  = CNT_W'(T_AS - 1);
    localparam logic [CNT_W-1:0] LAST_PW  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LAST_REC = CNT_W'(T_REC - 1);
    localparam logic [CNT_W:0]   MAXP     = (CNT_W+1)'(MAX_POLLS);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] poll_cnt, poll_cnt_nx;
    logic [CNT_W:0]   poll_next;
    logic             mode_q, mode_nx;
    logic             poll_q, poll_nx;
    logic             timeout_nx;
    logic             sample;
    logic             in_cycle_nx;

    // one bit wider so the +1 comparison cannot wrap at MAX_POLLS = 2^CNT_W-1
    assign poll_next   = {1'b0, poll_cnt} + (CNT_W+1)'(1);
    assign in_cycle_nx = (state_nx == SETUP) || (state_nx == EN_HI) || (state_nx == EN_LO);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CNT_W'(1);
        poll_cnt_nx = poll_cnt;
        mode_nx     = mode_q;
        poll_nx     = poll_q;
        timeout_nx  = timeout;
        sample      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (start) begin
                    state_nx    = SETUP;
                    mode_nx     = mode;
                    poll_nx     = poll & ~mode;
                    timeout_nx  = 1'b0;
                    poll_cnt_nx = '0;
                end
            end
            SETUP: begin
                if (cnt == LAST_AS) begin
                    state_nx = EN_HI;
                    cnt_nx   = '0;
                end
            end
            EN_HI: begin
                if (cnt == LAST_PW) begin
                    sample   = 1'b1;
                    state_nx = EN_LO;
                    cnt_nx   = '0;
                end
            end
            EN_LO: begin
                if (cnt == LAST_REC) begin
                    cnt_nx = '0;
                    // busy_flag here is the one sampled at the end of this EN_HI
                    if (poll_q && busy_flag && (poll_next < MAXP)) begin
                        poll_cnt_nx = poll_next[CNT_W-1:0];
                        state_nx    = SETUP;
                    end else begin
                        if (poll_q && busy_flag) timeout_nx = 1'b1;
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            poll_cnt <= '0;
            mode_q   <= 1'b0;
            poll_q   <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            poll_cnt <= poll_cnt_nx;
            mode_q   <= mode_nx;
            poll_q   <= poll_nx;
            timeout  <= timeout_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data   <= '0;
            busy_flag <= 1'b0;
            addr_cnt  <= '0;
        end else if (sample) begin
            rd_data <= lcd_data_in;
            if (!mode_q) begin
                busy_flag <= lcd_data_in[7];
                addr_cnt  <= lcd_data_in[6:0];
            end
        end
    end

    // Bus strobes come straight from flops (decoded from next state) so they cannot glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_en    <= 1'b0;
            bus_owned <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            lcd_rs    <= in_cycle_nx & mode_nx;
            lcd_rw    <= in_cycle_nx;
            lcd_en    <= (state_nx == EN_HI);
            bus_owned <= in_cycle_nx;
            busy      <= (state_nx != IDLE);
            done      <= (state_nx == DONE);
        end
    end

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side counterpart of the LCD write driver on the HD44780-compatible 16x2 character LCD.
- Performs timed read cycles (RW=1) on the LCD bus to return the busy flag, address counter, or a DDRAM/CGRAM data byte.
- Optional poll mode repeats status reads until the controller is ready or a poll limit is reached.
- Sits beside the LCD write driver. The top level muxes RS/RW/EN and tri-states LCD_DATA whenever bus_owned=1.

Parameters:
- T_AS, 8: clk cycles RS/RW setup before EN rises (≥140 ns at 50 MHz).
- T_PW, 25: clk cycles EN held high (≥450 ns).
- T_REC, 25: clk cycles EN low after a read, before the next cycle or release.
- MAX_POLLS, 255: maximum status reads in poll mode before timeout.
- CNT_W, 8: width of the timing and poll counters; must hold max(T_AS, T_PW, T_REC, MAX_POLLS).

Ports:
- clk, in, 1: system clock (CLOCK_50).
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: request pulse; sampled only in IDLE.
- mode, in, 1: 0 = status read (RS=0), 1 = data read (RS=1); latched on start.
- poll, in, 1: 1 = repeat status reads until BF=0; latched on start; ignored when mode=1.
- lcd_data_in, in, 8: LCD_DATA pins as seen from the input side.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: LCD read/write strobe, 1 = read.
- lcd_en, out, 1: LCD enable strobe.
- bus_owned, out, 1: reader controls the LCD bus; writer must hold off and LCD_DATA must be tri-stated.
- busy, out, 1: a transaction is in progress (state ≠ IDLE).
- done, out, 1: one-cycle completion pulse.
- rd_data, out, 8: last sampled byte.
- busy_flag, out, 1: rd_data[7] from the last status read.
- addr_cnt, out, 7: rd_data[6:0] from the last status read.
- timeout, out, 1: poll ended with BF still 1; held until the next start.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - All outputs 0, including lcd_en, which drops immediately even mid-EN_HI.
  - Counters are cleared; no done pulse is issued for an aborted transaction.
- States: IDLE, SETUP, EN_HI, EN_LO, DONE.
- IDLE:
  - start=1 latches mode and poll, clears timeout, zeroes the poll counter, and goes to SETUP.
  - start=0 stays in IDLE.
- SETUP, T_AS cycles:
  - lcd_rw=1, lcd_rs=mode, lcd_en=0, bus_owned=1.
  - Then goes to EN_HI.
- EN_HI, T_PW cycles:
  - lcd_en=1.
  - On the last EN_HI cycle, lcd_data_in is registered into rd_data.
  - If mode=0, busy_flag and addr_cnt update on the same edge.
  - If mode=1, busy_flag and addr_cnt keep their previous values.
  - Then goes to EN_LO.
- EN_LO, T_REC cycles:
  - lcd_en=0; RS and RW are held, bus_owned=1.
  - At the end of EN_LO:
    - If mode=0, poll=1, BF=1 and poll count+1 < MAX_POLLS: increment the poll count and go to SETUP. RS and RW stay asserted; there is no release gap.
    - Else if poll=1 and BF=1: set timeout=1 and go to DONE.
    - Otherwise go to DONE.
- DONE, 1 cycle:
  - done=1, lcd_rw=0, lcd_rs=0, bus_owned=0.
  - Returns to IDLE.
- Latency:
  - With start high at edge k, done is high during cycle k+1+T_AS+T_PW+T_REC (k+59 with defaults).
  - Each extra poll adds T_AS+T_PW+T_REC (58) cycles.
- Handshake rules:
  - start while busy=1 is ignored, not queued.
  - start held high continuously re-triggers on the cycle after DONE.
  - mode and poll are don't-care except on the accepted start cycle.
- rd_data, busy_flag and addr_cnt hold their values until the next sample. Only reset clears them.
- Poll count saturates: at most MAX_POLLS reads are performed, then timeout is set.
- Glitch-free bus control:
  - lcd_en only rises after a full T_AS with RS and RW stable.
  - RS and RW never change while lcd_en=1.
- The reader never drives LCD_DATA. bus_owned is the sole tri-state and mux control for the top level.

Test Plan:
- Reset mid-read: assert reset=0 during EN_HI → lcd_en=0 within the same cycle; all outputs 0; done never pulses. After release, a new start proceeds normally.
- Single status read: start=1, mode=0, poll=0, lcd_data_in=0x45 → lcd_en high for exactly 25 cycles after 8 setup cycles; done at k+59; rd_data=0x45, busy_flag=0, addr_cnt=0x45, lcd_rs=0 throughout.
- Data read: mode=1, lcd_data_in=0xC1 → lcd_rs=1 from SETUP through EN_LO; rd_data=0xC1; busy_flag and addr_cnt unchanged from their prior values.
- Poll success: poll=1, lcd_data_in=0x80 for the first 3 reads, then 0x12 → 4 EN pulses; done at k+1+4×58; busy_flag=0, addr_cnt=0x12, timeout=0.
- Poll timeout: MAX_POLLS=4, lcd_data_in=0xFF constant → exactly 4 EN pulses; done with timeout=1. The next start clears timeout.
- Ignored start: pulse start during SETUP of an active read → only one done; transaction count unchanged. bus_owned falls exactly on the DONE cycle.
